// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
//   Instruction fetch and decode stage. Holds the PC, drives an external
//   asynchronous instruction ROM, captures the returned word in a one-deep
//   instruction register (IR), and decodes the IR for the regfile/ALU datapath.
//   BNE is resolved here from the datapath's EQ flag. A taken branch redirects
//   the PC and flushes the wrong-path word fetched behind it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   stall       1 = hold PC, IR, ir_pc, ir_valid and the sticky illegal flag
//   instr       ROM data for instr_addr (combinational read)
//   EQ          datapath equality flag for the currently decoded instruction
//   instr_addr  current PC
//   rs1/rs2/rd  register indices IR[19:15] / IR[24:20] / IR[11:7]
//   ImmOp       sign-extended immediate
//   RegWrite    regfile write enable
//   ALUctrl     ALU operation: 000 add, 001 sub
//   ALUsrc      1 = ALU operand 2 is ImmOp
//   illegal     sticky: an unsupported opcode was decoded
//
// Handshake: there is no valid/ready pair. stall is a plain hold request:
//   while it is high nothing in this stage changes state and the decode
//   outputs are held. When the IR holds no valid word the decode outputs
//   are a bubble (all zero).
// -----------------------------------------------------------------------------
module fetch_decode #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    ALUctrl_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     EQ,
    output logic [DATA_WIDTH-1:0]    instr_addr,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     RegWrite,
    output logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic                     ALUsrc,
    output logic                     illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] ir_pc;
    logic                  ir_valid;
    logic                  illegal_q;

    logic                  legal;
    logic                  is_bne;
    logic                  taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Decode. Register fields are only driven for recognised instructions so
    // that a bubble is genuinely all-zero on every output.
    always_comb begin
        rs1      = '0;
        rs2      = '0;
        rd       = '0;
        ImmOp    = '0;
        RegWrite = 1'b0;
        ALUctrl  = '0;
        ALUsrc   = 1'b0;
        legal    = 1'b0;
        is_bne   = 1'b0;
        if (ir_valid) begin
            case (opcode)
                OP_IMM: begin
                    if (funct3 == 3'b000) begin
                        legal    = 1'b1;
                        RegWrite = 1'b1;
                        ALUsrc   = 1'b1;
                        ImmOp    = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
                    end
                end
                OP_REG: begin
                    if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                        legal    = 1'b1;
                        RegWrite = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    if (funct3 == 3'b001) begin
                        legal   = 1'b1;
                        is_bne  = 1'b1;
                        ALUctrl = ALUctrl_WIDTH'(1);
                        ImmOp   = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7],
                                   ir[30:25], ir[11:8], 1'b0};
                    end
                end
                default: legal = 1'b0;
            endcase
            if (legal) begin
                rs1 = ir[19:15];
                rs2 = ir[24:20];
                rd  = ir[11:7];
            end
        end
    end

    // is_bne already implies ir_valid.
    assign taken = is_bne & ~EQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            if (taken) begin
                // Redirect and drop the sequential word that would have been
                // fetched from ir_pc+4: one bubble cycle.
                pc       <= ir_pc + ImmOp;
                ir_valid <= 1'b0;
            end else begin
                ir       <= instr;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + DATA_WIDTH'(4);
            end
            if (ir_valid && !legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign instr_addr = pc;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode
//   Bench for fetch_decode. A 64-word ROM model answers instr_addr. The driver
//   pushes the expected outputs for each cycle into exp_q from an
//   instruction-level reference model; a separate monitor pops and compares.
//   Directed sequences cover reset, ADDI, taken/not-taken BNE, stall, illegal
//   and reset-vs-branch; a long randomized run follows.
// -----------------------------------------------------------------------------
module tb_fetch_decode;

  localparam int W = 85;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        EQ = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic        RegWrite;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic        illegal;

  logic [31:0] rom [64];
  assign instr = rom[instr_addr[7:2]];

  fetch_decode dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .instr      (instr),
    .EQ         (EQ),
    .instr_addr (instr_addr),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .ImmOp      (ImmOp),
    .RegWrite   (RegWrite),
    .ALUctrl    (ALUctrl),
    .ALUsrc     (ALUsrc),
    .illegal    (illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // reference model: architectural view of the stage
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rw;
    logic [2:0]  ctrl;
    logic        src;
    logic        bne;
    logic        legal;
  } dec_t;

  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_ir   = 32'h0;
  logic [31:0] m_irpc = 32'h0;
  logic        m_irv  = 1'b0;
  logic        m_ill  = 1'b0;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    d = '0;
    i12 = w[31:20];
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'd0) begin
      d.legal = 1'b1; d.rw = 1'b1; d.src = 1'b1; d.imm = 32'(i12);
    end else if (w[6:0] == 7'b0110011 && w[14:12] == 3'd0 && w[31:25] == 7'd0) begin
      d.legal = 1'b1; d.rw = 1'b1;
    end else if (w[6:0] == 7'b1100011 && w[14:12] == 3'd1) begin
      d.legal = 1'b1; d.bne = 1'b1; d.ctrl = 3'd1; d.imm = 32'(b13);
    end
    if (d.legal) begin
      d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    end
    return d;
  endfunction

  // driver: one cycle of stimulus, expected outputs for this cycle, model step
  task automatic step(input logic r, input logic s, input logic e);
    dec_t d;
    @(negedge clk);
    rst = r; stall = s; EQ = e;
    d = m_irv ? decode(m_ir) : '0;
    exp_q.push_back({m_pc, d.rs1, d.rs2, d.rd, d.imm, d.rw, d.ctrl, d.src, m_ill});
    if (r) begin
      m_pc = 32'h0; m_irv = 1'b0; m_irpc = 32'h0; m_ill = 1'b0;
    end else if (!s) begin
      if (m_irv && !d.legal) m_ill = 1'b1;
      if (d.bne && !e) begin
        m_pc  = m_irpc + d.imm;
        m_irv = 1'b0;
      end else begin
        m_ir   = rom[m_pc[7:2]];
        m_irpc = m_pc;
        m_irv  = 1'b1;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // sample just after the edge the last step applied to
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, c;
    logic [11:0] im;
    a = 5'($urandom); b = 5'($urandom); c = 5'($urandom); im = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: return {im, a, 3'b000, c, 7'b0010011};
      3, 4, 5: return {7'b0000000, b, a, 3'b000, c, 7'b0110011};
      6, 7:    return {im[11], im[9:4], b, a, 3'b001, im[3:0], im[10], 7'b1100011};
      8:       return $urandom;
      default: return {7'b0100000, b, a, 3'b000, c, 7'b0110011};
    endcase
  endfunction

  task automatic load_directed();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'hFFB0_0093;  // addi x1,x0,-5
    rom[1] = 32'h0020_81B3;  // add  x3,x1,x2
    rom[2] = 32'hFE00_9CE3;  // bne  x1,x0,-8
    rom[3] = 32'h0070_0113;  // addi x2,x0,7
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {instr_addr, rs1, rs2, rd, ImmOp, RegWrite, ALUctrl, ALUsrc, illegal};
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got %h expected %h", $time, act, e);
        end
      end
    end
  end

  initial begin
    // reset and release
    step(1, 0, 1);
    load_directed();
    step(1, 0, 1);
    settle();
    chk("reset_pc", instr_addr, 32'h0);
    chk("reset_regwrite", {31'd0, RegWrite}, 32'h0);
    chk("reset_illegal", {31'd0, illegal}, 32'h0);

    // ADDI x1,x0,-5 decoded
    step(0, 0, 1); settle();
    chk("pc_4", instr_addr, 32'h4);
    chk("addi_imm", ImmOp, 32'hFFFF_FFFB);
    chk("addi_rd", {27'd0, rd}, 32'd1);
    chk("addi_rs1", {27'd0, rs1}, 32'd0);
    chk("addi_alusrc", {31'd0, ALUsrc}, 32'd1);
    chk("addi_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("addi_aluctrl", {29'd0, ALUctrl}, 32'd0);
    step(0, 0, 1); settle();
    chk("pc_8", instr_addr, 32'h8);
    step(0, 0, 1); settle();
    chk("bne_aluctrl", {29'd0, ALUctrl}, 32'd1);
    chk("bne_imm", ImmOp, 32'hFFFF_FFF8);

    // BNE taken: redirect to 0 with one bubble
    step(0, 0, 0); settle();
    chk("taken_pc", instr_addr, 32'h0);
    chk("taken_bubble", {31'd0, RegWrite}, 32'd0);
    step(0, 0, 1); settle();
    chk("after_bubble_regwrite", {31'd0, RegWrite}, 32'd1);

    // BNE not taken: continue to 16 with no bubble
    step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 1); settle();
    chk("not_taken_pc", instr_addr, 32'h10);
    chk("not_taken_regwrite", {31'd0, RegWrite}, 32'd1);

    // stall for 3 cycles
    step(0, 0, 1);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 0); settle();
    chk("stall_pc", instr_addr, 32'h14);
    step(0, 0, 1); settle();
    chk("resume_pc", instr_addr, 32'h18);

    // reset on the same edge as a taken BNE
    step(1, 0, 1);
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1); settle();
    chk("bne_in_ir_pc", instr_addr, 32'hC);
    step(1, 0, 0); settle();
    chk("rst_beats_branch_pc", instr_addr, 32'h0);
    chk("rst_beats_branch_rw", {31'd0, RegWrite}, 32'd0);

    // illegal all-zero word
    rom[0] = 32'h0;
    step(1, 0, 1);
    step(0, 0, 1); settle();
    chk("illegal_bubble_rw", {31'd0, RegWrite}, 32'd0);
    chk("illegal_not_yet", {31'd0, illegal}, 32'd0);
    step(0, 0, 1); settle();
    chk("illegal_set", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    settle();
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);
    step(1, 0, 1); settle();
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);

    // randomized run
    for (int i = 0; i < 64; i++) rom[i] = rand_instr();
    step(1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
